// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-16 generator/checker pair:
// polynomial taps, register width and the checker's lock states.
package prbs_pkg;

   localparam int PRBS_W = 16;

   // Taps for x^16+x^14+x^13+x^11+1 on a left-shifting register
   localparam logic [PRBS_W-1:0] PRBS16_TAPS = 16'hB400;

   typedef enum logic [1:0] {
      SEED,
      VERIFY,
      LOCKED
   } prbs_state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear takes priority
// over the increment.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/prbs16_checker.sv
// Self-synchronising PRBS-16 checker: seeds from the line, verifies the seed,
// then free-runs its own LFSR and counts/windows the bit errors it sees.
module prbs16_checker
   import prbs_pkg::*;
#(
   parameter int LOCK_CNT  = 16,
   parameter int WINDOW    = 64,
   parameter int ERR_LIMIT = 4,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             din,
   input  logic             clr_count,
   output logic             locked,
   output logic             err,
   output logic [CNT_W-1:0] err_count
);

   localparam int WIN_W = $clog2(WINDOW);

   prbs_state_t       state, state_n;
   logic [PRBS_W-1:0] r, r_n;
   logic [3:0]        seed_cnt, seed_cnt_n;
   logic [7:0]        match_cnt, match_cnt_n;
   logic [WIN_W-1:0]  win_cnt, win_cnt_n;
   logic [8:0]        win_err, win_err_n;
   logic [8:0]        win_err_inc;
   logic              pred;
   logic              mis;
   logic              err_n;

   always_comb begin
      state_n     = state;
      r_n         = r;
      seed_cnt_n  = seed_cnt;
      match_cnt_n = match_cnt;
      win_cnt_n   = win_cnt;
      win_err_n   = win_err;
      err_n       = 1'b0;
      pred        = ^(r & PRBS16_TAPS);
      mis         = din ^ pred;
      win_err_inc = win_err + 9'(mis);

      if (enable) begin
         case (state)
            SEED: begin
               r_n        = {r[PRBS_W-2:0], din};
               seed_cnt_n = seed_cnt + 4'd1;
               // An all-zero seed is the LFSR lock-up state; keep seeding
               if ((seed_cnt == 4'd15) && (r_n != '0)) begin
                  state_n     = VERIFY;
                  match_cnt_n = '0;
               end
            end
            VERIFY: begin
               r_n = {r[PRBS_W-2:0], din};
               if (!mis) begin
                  if ((9'(match_cnt) + 9'd1) == 9'(LOCK_CNT)) begin
                     state_n     = LOCKED;
                     match_cnt_n = '0;
                     win_cnt_n   = '0;
                     win_err_n   = '0;
                  end else begin
                     match_cnt_n = match_cnt + 8'd1;
                  end
               end else begin
                  state_n     = SEED;
                  seed_cnt_n  = '0;
                  match_cnt_n = '0;
               end
            end
            LOCKED: begin
               // Free-run on the prediction so a line error is seen only once
               r_n   = {r[PRBS_W-2:0], pred};
               err_n = mis;
               if (win_err_inc == 9'(ERR_LIMIT)) begin
                  state_n    = SEED;
                  seed_cnt_n = '0;
                  win_cnt_n  = '0;
                  win_err_n  = '0;
               end else if (win_cnt == WIN_W'(WINDOW - 1)) begin
                  win_cnt_n = '0;
                  win_err_n = '0;
               end else begin
                  win_cnt_n = win_cnt + 1'b1;
                  win_err_n = win_err_inc;
               end
            end
            default: state_n = SEED;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= SEED;
         r         <= '0;
         seed_cnt  <= '0;
         match_cnt <= '0;
         win_cnt   <= '0;
         win_err   <= '0;
         locked    <= 1'b0;
         err       <= 1'b0;
      end else begin
         state     <= state_n;
         r         <= r_n;
         seed_cnt  <= seed_cnt_n;
         match_cnt <= match_cnt_n;
         win_cnt   <= win_cnt_n;
         win_err   <= win_err_n;
         locked    <= (state_n == LOCKED);
         err       <= err_n;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_err_cnt (
      .clk   (clk),
      .reset (reset),
      .clr   (clr_count),
      .inc   (err_n),
      .count (err_count)
   );

endmodule

// File: tb/tb_prbs16_checker.sv
// Bench for prbs16_checker: a default instance and a CNT_W=4/ERR_LIMIT=64
// instance share one stimulus stream and are checked against a bit-history model.
module tb_prbs16_checker;

   logic        clk;
   logic        reset;
   logic        enable;
   logic        din;
   logic        clr_count;
   logic        locked0, err0;
   logic [15:0] cnt0;
   logic        locked1, err1;
   logic [3:0]  cnt1;

   prbs16_checker dut (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .din       (din),
      .clr_count (clr_count),
      .locked    (locked0),
      .err       (err0),
      .err_count (cnt0)
   );

   prbs16_checker #(
      .LOCK_CNT  (16),
      .WINDOW    (64),
      .ERR_LIMIT (64),
      .CNT_W     (4)
   ) dut_s (
      .clk       (clk),
      .reset     (reset),
      .enable    (enable),
      .din       (din),
      .clr_count (clr_count),
      .locked    (locked1),
      .err       (err1),
      .err_count (cnt1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int checks = 0;
   int errors = 0;
   bit run_cmp = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each instance keeps the history of bits that entered its register.
   // The next PRBS bit is b[n-16]^b[n-14]^b[n-13]^b[n-11].
   bit hist [2][8192];
   int n      [2];
   int mode   [2];   // 0 seeding, 1 verifying, 2 locked
   int cnt    [2];
   int wpos   [2];
   int werr   [2];
   int ecount [2];
   bit eerr   [2];
   bit elock  [2];
   int limit  [2] = '{4, 64};
   int cmax   [2] = '{65535, 15};

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) hist[k][i] = 1'b0;
         n[k] = 16; mode[k] = 0; cnt[k] = 0; wpos[k] = 0; werr[k] = 0;
         ecount[k] = 0; eerr[k] = 1'b0; elock[k] = 1'b0;
      end
   endtask

   function automatic bit mpred(int k);
      return hist[k][n[k]-16] ^ hist[k][n[k]-14] ^ hist[k][n[k]-13] ^ hist[k][n[k]-11];
   endfunction

   function automatic bit last16_zero(int k);
      for (int i = 1; i <= 16; i++) if (hist[k][n[k]-i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_step(input bit en, input bit d, input bit clr);
      for (int k = 0; k < 2; k++) begin
         bit p;
         eerr[k] = 1'b0;
         if (en) begin
            p = mpred(k);
            if (mode[k] == 0) begin
               hist[k][n[k]] = d; n[k]++;
               cnt[k]++;
               if (cnt[k] == 16) begin
                  cnt[k] = 0;
                  if (!last16_zero(k)) mode[k] = 1;
               end
            end else if (mode[k] == 1) begin
               hist[k][n[k]] = d; n[k]++;
               if (d == p) begin
                  cnt[k]++;
                  if (cnt[k] == 16) begin
                     mode[k] = 2; cnt[k] = 0; wpos[k] = 0; werr[k] = 0;
                  end
               end else begin
                  mode[k] = 0; cnt[k] = 0;
               end
            end else begin
               hist[k][n[k]] = p; n[k]++;
               if (d != p) begin
                  eerr[k] = 1'b1;
                  werr[k]++;
               end
               if (werr[k] == limit[k]) begin
                  mode[k] = 0; cnt[k] = 0; wpos[k] = 0; werr[k] = 0;
               end else begin
                  wpos[k]++;
                  if (wpos[k] == 64) begin
                     wpos[k] = 0; werr[k] = 0;
                  end
               end
            end
         end
         if (clr) ecount[k] = 0;
         else if (eerr[k] && ecount[k] < cmax[k]) ecount[k]++;
         elock[k] = (mode[k] == 2);
      end
   endtask

   always @(negedge clk) begin
      if (run_cmp && !reset) begin
         chk("locked0", locked0, elock[0]);
         chk("err0",    err0,    eerr[0]);
         chk("cnt0",    cnt0,    ecount[0]);
         chk("locked1", locked1, elock[1]);
         chk("err1",    err1,    eerr[1]);
         chk("cnt1",    cnt1,    ecount[1]);
      end
   end

   logic [15:0] g;
   int bitno;

   // Drive one cycle just after the falling edge; return 1 ns after the rising edge
   task automatic cyc(input bit en, input bit d, input bit clr);
      @(negedge clk); #1;
      enable = en; din = d; clr_count = clr;
      model_step(en, d, clr);
      @(posedge clk); #1;
   endtask

   task automatic gbit(input bit flip);
      bit fb;
      fb = g[15] ^ g[13] ^ g[12] ^ g[10];
      g = {g[14:0], fb};
      bitno++;
      cyc(1'b1, fb ^ flip, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk); #3;
      reset = 1'b1;
      model_reset();
      bitno = 0;
      #1;
      chk("rst_locked0", locked0, 0);
      chk("rst_err0",    err0,    0);
      chk("rst_cnt0",    cnt0,    0);
      chk("rst_locked1", locked1, 0);
      chk("rst_err1",    err1,    0);
      chk("rst_cnt1",    cnt1,    0);
      @(negedge clk); #1;
      enable = 1'b0; clr_count = 1'b0;
      reset = 1'b0;
   endtask

   initial begin
      int k;
      reset = 1'b1; enable = 1'b0; din = 1'b0; clr_count = 1'b0;
      g = 16'hACE1; bitno = 0;
      model_reset();
      @(posedge clk); #1;
      chk("init_locked0", locked0, 0);
      chk("init_cnt0",    cnt0,    0);
      chk("init_err1",    err1,    0);
      @(negedge clk); #1;
      reset = 1'b0;
      run_cmp = 1'b1;

      // Clean stream: lock exactly on bit 32
      for (int i = 0; i < 31; i++) gbit(1'b0);
      chk("lock_bit31", locked0, 0);
      gbit(1'b0);
      chk("lock_bit32", locked0, 1);
      chk("lock_bit32_s", locked1, 1);
      for (int i = 0; i < 1000; i++) gbit(1'b0);
      chk("clean_cnt0", cnt0, 0);
      chk("clean_locked0", locked0, 1);

      // Single flipped bit while locked
      gbit(1'b1);
      chk("flip_err0", err0, 1);
      chk("flip_cnt0", cnt0, 1);
      chk("flip_cnt1", cnt1, 1);
      chk("flip_locked0", locked0, 1);
      gbit(1'b0);
      chk("flip_err0_next", err0, 0);
      for (int i = 0; i < 200; i++) gbit(1'b0);
      chk("flip_cnt0_after", cnt0, 1);

      // Clear while disabled, then a 4-error burst inside one window
      while (((bitno + 1 - 33) % 64) != 5) gbit(1'b0);
      cyc(1'b0, 1'b1, 1'b1);
      chk("clr_dis_cnt0", cnt0, 0);
      chk("clr_dis_err0", err0, 0);
      for (int i = 0; i < 4; i++) begin
         gbit(1'b1);
         if (i < 3) begin
            chk("burst_locked0", locked0, 1);
            gbit(1'b0);
            gbit(1'b0);
         end
      end
      chk("burst_unlock0", locked0, 0);
      chk("burst_err0", err0, 1);
      chk("burst_cnt0", cnt0, 4);
      chk("burst_locked1", locked1, 1);
      chk("burst_cnt1", cnt1, 4);
      for (int i = 0; i < 31; i++) gbit(1'b0);
      chk("relock_31", locked0, 0);
      gbit(1'b0);
      chk("relock_32", locked0, 1);

      // All-zero input, then the stream
      do_reset();
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0);
      chk("zeros_locked0", locked0, 0);
      k = 0;
      while (!locked0 && k < 150) begin
         gbit(1'b0);
         k++;
      end
      chk("zeros_lock_seen", locked0, 1);
      chk("zeros_lock_min", (k >= 32) ? 1 : 0, 1);

      // Enable toggling every cycle: lock counts enabled bits
      do_reset();
      for (int i = 0; i < 64; i++) begin
         if (i % 2 == 0) gbit(1'b0);
         else cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         if (i == 61) begin
            chk("tog_lock31", locked0, 0);
            chk("tog_lock31_s", locked1, 0);
         end
         if (i == 62) begin
            chk("tog_lock32", locked0, 1);
            chk("tog_lock32_s", locked1, 1);
         end
      end

      // Saturation of the 4-bit counter, clear against an error, async reset
      for (int i = 0; i < 20; i++) begin
         gbit(1'b1);
         gbit(1'b0);
         gbit(1'b0);
      end
      chk("sat_cnt1", cnt1, 15);
      chk("sat_locked1", locked1, 1);
      begin
         bit fb;
         fb = g[15] ^ g[13] ^ g[12] ^ g[10];
         g = {g[14:0], fb};
         bitno++;
         cyc(1'b1, ~fb, 1'b1);
      end
      chk("clr_err_err1", err1, 1);
      chk("clr_err_cnt1", cnt1, 0);
      gbit(1'b1);
      chk("pre_rst_err1", err1, 1);
      chk("pre_rst_cnt1", cnt1, 1);
      do_reset();
      for (int i = 0; i < 8; i++) gbit(1'b0);

      run_cmp = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
